// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the memory port arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and SRAM-style memory bus signals of the arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_ready;
    logic                  inst_rvalid;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_ready;
    logic                  data_rvalid;
    logic [DATA_W-1:0]     data_rdata;

    logic                  mem_req;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wstrb, data_addr, data_wdata,
        input  mem_ack, mem_rvalid, mem_rdata,
        output inst_ready, inst_rvalid, inst_rdata,
        output data_ready, data_rvalid, data_rdata,
        output mem_req, mem_wstrb, mem_addr, mem_wdata
    );

    // Core + memory side
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wstrb, data_addr, data_wdata,
        output mem_ack, mem_rvalid, mem_rdata,
        input  inst_ready, inst_rvalid, inst_rdata,
        input  data_ready, data_rvalid, data_rdata,
        input  mem_req, mem_wstrb, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// =============================================================================
// Module      : starve_counter
// Description : Saturating count of fetch arbitration losses.
// Revision    : 1.0 - initial release
// =============================================================================
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign at_limit = (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and load/store requesters.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic                w_inst_win;
    logic                w_data_win;
    logic                w_starve_hit;
    logic                w_resp;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (4)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .inc      (w_data_win && bus.inst_req),
        .clr      (w_inst_win),
        .at_limit (w_starve_hit)
    );

    // Data normally wins; fetch wins when alone or once it has been starved long enough.
    always_comb begin
        w_state_nxt = r_state;
        w_inst_win  = 1'b0;
        w_data_win  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.inst_req && (!bus.data_req || w_starve_hit)) begin
                    w_inst_win = 1'b1;
                end else if (bus.data_req) begin
                    w_data_win = 1'b1;
                end
                if (w_inst_win || w_data_win) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_DATA;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_inst_win) begin
            r_owner <= OWN_INST;
            r_addr  <= bus.inst_addr;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_data_win) begin
            r_owner <= OWN_DATA;
            r_addr  <= bus.data_addr;
            r_wdata <= bus.data_wdata;
            r_wstrb <= bus.data_wstrb;
        end
    end

    assign w_resp          = (r_state == WAIT) && bus.mem_rvalid;

    assign bus.inst_ready  = w_inst_win;
    assign bus.data_ready  = w_data_win;
    assign bus.inst_rvalid = w_resp && (r_owner == OWN_INST);
    assign bus.data_rvalid = w_resp && (r_owner == OWN_DATA);
    assign bus.inst_rdata  = bus.mem_rdata;
    assign bus.data_rdata  = bus.mem_rdata;

    assign bus.mem_req     = (r_state == REQ);
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.mem_wstrb   = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a simple SRAM model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        owner_t      owner;
        logic        check_data;
        logic [31:0] data;
    } resp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    req_t  exp_req[$];
    resp_t exp_resp[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_delay = 0;
    int resp_delay = 0;
    int inst_left = 0;
    int data_left = 0;
    int inst_ready_cnt = 0;
    int data_ready_cnt = 0;
    int rvalid_cnt = 0;
    int first_ready_cyc = -1;
    int last_ready_cyc = 0;
    int last_rvalid_cyc = 0;
    int req_len = 0;
    int last_req_len = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h1FC0_0000) ? 32'h3C08_0001 : (a ^ 32'hA5A5_0F0F);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: ack after ack_delay cycles of mem_req, response resp_delay cycles later
    int          mem_req_cycles;
    logic        mem_pend;
    int          mem_rcnt;
    logic [31:0] mem_raddr;

    assign bus.mem_ack = bus.mem_req && (mem_req_cycles >= ack_delay);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req_cycles <= 0;
            mem_pend       <= 1'b0;
            mem_rcnt       <= 0;
            mem_raddr      <= '0;
            bus.mem_rvalid <= 1'b0;
            bus.mem_rdata  <= '0;
        end else begin
            bus.mem_rvalid <= 1'b0;
            if (bus.mem_req && !bus.mem_ack) mem_req_cycles <= mem_req_cycles + 1;
            else                             mem_req_cycles <= 0;
            if (bus.mem_req && bus.mem_ack) begin
                if (resp_delay == 0) begin
                    bus.mem_rvalid <= 1'b1;
                    bus.mem_rdata  <= mem_data(bus.mem_addr);
                end else begin
                    mem_pend  <= 1'b1;
                    mem_rcnt  <= 1;
                    mem_raddr <= bus.mem_addr;
                end
            end else if (mem_pend) begin
                if (mem_rcnt >= resp_delay) begin
                    bus.mem_rvalid <= 1'b1;
                    bus.mem_rdata  <= mem_data(mem_raddr);
                    mem_pend       <= 1'b0;
                end else begin
                    mem_rcnt <= mem_rcnt + 1;
                end
            end
        end
    end

    // Scoreboard monitor
    req_t        m_req;
    resp_t       m_resp;
    logic [31:0] m_rdata;
    logic        inst_hold = 1'b0;
    logic        data_hold = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.inst_ready || bus.data_ready) begin
                checks++;
                if (bus.inst_ready && bus.data_ready) begin
                    failures++;
                    $display("FAIL dual_ready: both readys high at cycle %0d, required one", cyc);
                end
                if (bus.inst_ready) inst_ready_cnt++;
                if (bus.data_ready) data_ready_cnt++;
                if (first_ready_cyc < 0) first_ready_cyc = cyc;
                last_ready_cyc = cyc;
            end
            if (bus.mem_req) begin
                req_len++;
                checks++;
                if (exp_req.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_mem_req: addr=%h with no transaction expected", bus.mem_addr);
                end else begin
                    m_req = exp_req[0];
                    if (bus.mem_addr !== m_req.addr || bus.mem_wstrb !== m_req.wstrb ||
                        (m_req.wstrb != 4'b0 && bus.mem_wdata !== m_req.wdata)) begin
                        failures++;
                        $display("FAIL mem_fields: got addr=%h wstrb=%b wdata=%h, required addr=%h wstrb=%b wdata=%h",
                                 bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, m_req.addr, m_req.wstrb, m_req.wdata);
                    end
                    if (bus.mem_ack) begin
                        exp_req.delete(0);
                        last_req_len = req_len;
                        req_len = 0;
                    end
                end
            end
            if (bus.inst_rvalid || bus.data_rvalid) begin
                rvalid_cnt++;
                last_rvalid_cyc = cyc;
                checks++;
                if (exp_resp.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rvalid: inst_rvalid=%b data_rvalid=%b, required none",
                             bus.inst_rvalid, bus.data_rvalid);
                end else begin
                    m_resp = exp_resp[0];
                    exp_resp.delete(0);
                    m_rdata = (m_resp.owner == OWN_INST) ? bus.inst_rdata : bus.data_rdata;
                    if (bus.inst_rvalid !== (m_resp.owner == OWN_INST) ||
                        bus.data_rvalid !== (m_resp.owner == OWN_DATA) || bus.mem_rvalid !== 1'b1) begin
                        failures++;
                        $display("FAIL rvalid_owner: inst_rvalid=%b data_rvalid=%b mem_rvalid=%b, required owner=%s",
                                 bus.inst_rvalid, bus.data_rvalid, bus.mem_rvalid, m_resp.owner.name());
                    end else if (m_resp.check_data && m_rdata !== m_resp.data) begin
                        failures++;
                        $display("FAIL rdata: got %h, required %h", m_rdata, m_resp.data);
                    end
                end
            end
            assert (!(inst_hold && !bus.inst_req))
                else $error("FAIL protocol: inst_req dropped before inst_ready");
            assert (!(data_hold && !bus.data_req))
                else $error("FAIL protocol: data_req dropped before data_ready");
            inst_hold = bus.inst_req && !bus.inst_ready;
            data_hold = bus.data_req && !bus.data_ready;
        end else begin
            inst_hold = 1'b0;
            data_hold = 1'b0;
        end
    end

    // One cycle of requester behaviour: hold req, advance to the next address on ready
    task automatic step();
        logic ir, dr;
        @(negedge clock);
        ir = bus.inst_ready;
        dr = bus.data_ready;
        @(posedge clock);
        #1;
        if (ir) begin
            if (inst_left > 1) begin
                inst_left--;
                bus.inst_addr = bus.inst_addr + 32'd4;
            end else begin
                inst_left = 0;
                bus.inst_req = 1'b0;
            end
        end
        if (dr) begin
            if (data_left > 1) begin
                data_left--;
                bus.data_addr = bus.data_addr + 32'd4;
            end else begin
                data_left = 0;
                bus.data_req = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((exp_req.size() != 0 || exp_resp.size() != 0 || bus.inst_req || bus.data_req) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: %0d cycles with %0d req / %0d resp pending, required 0",
                     name, n, exp_req.size(), exp_resp.size());
        end
    endtask

    task automatic clear_stats();
        inst_ready_cnt  = 0;
        data_ready_cnt  = 0;
        rvalid_cnt      = 0;
        first_ready_cyc = -1;
        req_len         = 0;
        last_req_len    = 0;
    endtask

    task automatic expect_txn(input owner_t o, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_req.push_back('{addr: a, wstrb: s, wdata: d});
        exp_resp.push_back('{owner: o, check_data: (s == 4'b0), data: mem_data(a)});
    endtask

    task automatic issue_inst(input logic [31:0] a, input int n);
        bus.inst_addr = a;
        bus.inst_req  = 1'b1;
        inst_left     = n;
    endtask

    task automatic issue_data(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int n);
        bus.data_addr  = a;
        bus.data_wstrb = s;
        bus.data_wdata = d;
        bus.data_req   = 1'b1;
        data_left      = n;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL reset_mem_req: got %b, required 0", bus.mem_req);
        end
        checks++;
        if (bus.mem_addr !== 32'h0) begin
            failures++; $display("FAIL reset_mem_addr: got %h, required 0", bus.mem_addr);
        end
        checks++;
        if (bus.mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_mem_wdata: got %h, required 0", bus.mem_wdata);
        end
        checks++;
        if (bus.mem_wstrb !== 4'h0) begin
            failures++; $display("FAIL reset_mem_wstrb: got %b, required 0", bus.mem_wstrb);
        end
        checks++;
        if ({bus.inst_ready, bus.data_ready, bus.inst_rvalid, bus.data_rvalid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_handshake: ready/rvalid=%b, required 0000",
                     {bus.inst_ready, bus.data_ready, bus.inst_rvalid, bus.data_rvalid});
        end
    endtask

    task automatic test_fetch_only();
        clear_stats();
        ack_delay = 0; resp_delay = 0;
        expect_txn(OWN_INST, 32'h1FC0_0000, 4'b0, 32'h0);
        issue_inst(32'h1FC0_0000, 1);
        wait_done(50, "fetch_only");
        checks++;
        if (inst_ready_cnt != 1 || data_ready_cnt != 0) begin
            failures++;
            $display("FAIL fetch_ready: inst_ready=%0d data_ready=%0d, required 1 and 0", inst_ready_cnt, data_ready_cnt);
        end
        checks++;
        if (rvalid_cnt != 1 || last_rvalid_cyc - last_ready_cyc != 2) begin
            failures++;
            $display("FAIL fetch_latency: rvalids=%0d latency=%0d, required 1 and 2",
                     rvalid_cnt, last_rvalid_cyc - last_ready_cyc);
        end
        checks++;
        if (last_req_len != 1) begin
            failures++; $display("FAIL fetch_req_len: got %0d, required 1", last_req_len);
        end
    endtask

    task automatic test_priority();
        clear_stats();
        expect_txn(OWN_DATA, 32'h8000_0010, 4'b0, 32'h0);
        expect_txn(OWN_INST, 32'h1FC0_0004, 4'b0, 32'h0);
        issue_inst(32'h1FC0_0004, 1);
        issue_data(32'h8000_0010, 4'b0, 32'h0, 1);
        wait_done(50, "priority");
        checks++;
        if (inst_ready_cnt != 1 || data_ready_cnt != 1) begin
            failures++;
            $display("FAIL priority_ready: inst=%0d data=%0d, required 1 and 1", inst_ready_cnt, data_ready_cnt);
        end
    endtask

    task automatic test_starvation();
        clear_stats();
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < STARVE_LIMIT; k++)
                expect_txn(OWN_DATA, 32'h8000_0100 + 32'(4 * (STARVE_LIMIT * g + k)), 4'b0, 32'h0);
            expect_txn(OWN_INST, 32'h0040_0000 + 32'(4 * g), 4'b0, 32'h0);
        end
        issue_inst(32'h0040_0000, 2);
        issue_data(32'h8000_0100, 4'b0, 32'h0, 2 * STARVE_LIMIT);
        wait_done(200, "starvation");
        checks++;
        if (data_ready_cnt != 2 * STARVE_LIMIT || inst_ready_cnt != 2) begin
            failures++;
            $display("FAIL starve_grants: data=%0d inst=%0d, required %0d and 2",
                     data_ready_cnt, inst_ready_cnt, 2 * STARVE_LIMIT);
        end
        checks++;
        if (last_rvalid_cyc - first_ready_cyc != 3 * (2 * STARVE_LIMIT + 2) - 1) begin
            failures++;
            $display("FAIL throughput: span=%0d cycles, required %0d",
                     last_rvalid_cyc - first_ready_cyc, 3 * (2 * STARVE_LIMIT + 2) - 1);
        end
    endtask

    task automatic test_store();
        int n = 0;
        clear_stats();
        ack_delay = 3; resp_delay = 0;
        expect_txn(OWN_DATA, 32'h8000_0020, 4'b0011, 32'hDEAD_BEEF);
        issue_data(32'h8000_0020, 4'b0011, 32'hDEAD_BEEF, 1);
        step();
        expect_txn(OWN_INST, 32'h1FC0_0010, 4'b0, 32'h0);
        issue_inst(32'h1FC0_0010, 1);
        while (rvalid_cnt < 1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (rvalid_cnt != 1 || inst_ready_cnt != 0) begin
            failures++;
            $display("FAIL store_blocking: rvalids=%0d inst_ready=%0d, required 1 and 0", rvalid_cnt, inst_ready_cnt);
        end
        checks++;
        if (last_req_len != 4 || last_rvalid_cyc - last_ready_cyc != 5) begin
            failures++;
            $display("FAIL store_timing: req_len=%0d latency=%0d, required 4 and 5",
                     last_req_len, last_rvalid_cyc - last_ready_cyc);
        end
        wait_done(50, "store");
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        clear_stats();
        ack_delay = 0; resp_delay = 0;
        exp_req.push_back('{addr: 32'h1FC0_0008, wstrb: 4'b0, wdata: 32'h0});
        issue_inst(32'h1FC0_0008, 1);
        step();
        step();
        checks++;
        if (bus.inst_rvalid !== 1'b1) begin
            failures++; $display("FAIL wait_rvalid: got %b, required 1 before reset", bus.inst_rvalid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.inst_rvalid, bus.data_rvalid} !== 3'b000 || bus.mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: req/irv/drv=%b addr=%h, required 000 and 0",
                     {bus.mem_req, bus.inst_rvalid, bus.data_rvalid}, bus.mem_addr);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_stats();
        expect_txn(OWN_INST, 32'h1FC0_0000, 4'b0, 32'h0);
        issue_inst(32'h1FC0_0000, 1);
        wait_done(50, "after_reset");
        checks++;
        if (inst_ready_cnt != 1 || rvalid_cnt != 1 || last_rvalid_cyc - last_ready_cyc != 2) begin
            failures++;
            $display("FAIL after_reset_fetch: ready=%0d rvalids=%0d latency=%0d, required 1 1 2",
                     inst_ready_cnt, rvalid_cnt, last_rvalid_cyc - last_ready_cyc);
        end
    endtask

    initial begin
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wstrb = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        test_fetch_only();
        test_priority();
        test_starvation();
        test_store();
        test_reset_mid();
        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
